// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
// master = byte source plus word consumer, slave = packer.
interface byte_word_packer_if #(
  parameter int CHANNELS       = 2,
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4
);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int LEN_W  = $clog2(BYTES_PER_WORD + 1);

  logic [CHANNELS*BYTE_W-1:0] in_data;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS-1:0]        in_ready;
  logic [CHANNELS-1:0]        flush;
  logic [CHANNELS*WORD_W-1:0] out_data;
  logic [CHANNELS*LEN_W-1:0]  out_len;
  logic [CHANNELS-1:0]        out_valid;
  logic [CHANNELS-1:0]        out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_len, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_len, out_valid
  );
endinterface

// File: rtl/byte_word_packer.sv
// Per-channel byte-to-word packer with output register
// and partial-word flush.
module byte_word_packer #(
  parameter int CHANNELS       = 2,
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1
) (
  input logic clk,
  input logic rst_n,
  byte_word_packer_if.slave bus
);
  localparam int N      = BYTES_PER_WORD;
  localparam int WORD_W = BYTE_W * N;
  localparam int LEN_W  = $clog2(N + 1);
  localparam int IDX_W  = $clog2(N);
  localparam logic [LEN_W-1:0] LAST = LEN_W'(N - 1);

  typedef enum logic {FILL, FLUSH_WAIT} state_e;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e                   st_q, st_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d, cnt_acc;
    logic [N-1:0][BYTE_W-1:0] sh_q, sh_d, sh_acc;
    logic [WORD_W-1:0]        od_q, od_d, word;
    logic [LEN_W-1:0]         ol_q, ol_d;
    logic                     ov_q, ov_d;
    logic [BYTE_W-1:0]        byte_in;
    logic slot_free, rdy, acc, done, fl_req;

    assign byte_in   = bus.in_data[c*BYTE_W +: BYTE_W];
    assign slot_free = !ov_q || bus.out_ready[c];
    assign rdy       = (st_q == FILL) &&
                       ((cnt_q < LAST) || slot_free);
    assign acc       = bus.in_valid[c] && rdy;
    assign done      = acc && (cnt_q == LAST);
    assign fl_req    = (bus.flush[c] || st_q == FLUSH_WAIT) &&
                       (cnt_acc != '0);

    // Byte accepted this cycle is merged before any emit decision.
    always_comb begin
      sh_acc  = sh_q;
      cnt_acc = cnt_q + LEN_W'(acc);
      if (acc) sh_acc[cnt_q[IDX_W-1:0]] = byte_in;
      word = '0;
      for (int i = 0; i < N; i++) begin
        if (MSB_FIRST)
          word[(N-1-i)*BYTE_W +: BYTE_W] = sh_acc[i];
        else
          word[i*BYTE_W +: BYTE_W] = sh_acc[i];
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_acc;
      sh_d  = sh_acc;
      od_d  = od_q;
      ol_d  = ol_q;
      ov_d  = ov_q && !bus.out_ready[c];
      if (done || (fl_req && slot_free)) begin
        od_d  = word;
        ol_d  = cnt_acc;
        ov_d  = 1'b1;
        cnt_d = '0;
        sh_d  = '0;
        st_d  = FILL;
      end else if (fl_req) begin
        st_d = FLUSH_WAIT;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= FILL;
        cnt_q <= '0;
        sh_q  <= '0;
        od_q  <= '0;
        ol_q  <= '0;
        ov_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        sh_q  <= sh_d;
        od_q  <= od_d;
        ol_q  <= ol_d;
        ov_q  <= ov_d;
      end
    end

    assign bus.in_ready[c]                    = rdy;
    assign bus.out_data[c*WORD_W +: WORD_W]   = od_q;
    assign bus.out_len[c*LEN_W +: LEN_W]      = ol_q;
    assign bus.out_valid[c]                   = ov_q;
  end
endmodule
